// File: rtl/gpu_tile_renderer.sv
// Tile-mode VGA renderer: pixel-enable timing generator, dual-access tile RAM,
// writable RGB565 palette and a three-stage pixel pipeline.
module gpu_tile_renderer #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SW      = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SW      = 2,
    parameter int V_BP      = 33,
    parameter int CLK_DIV   = 2,
    parameter int CELL_LOG2 = 4,
    parameter int BPP       = 4,
    parameter int SYNC_POL  = 0,
    parameter int ADDR_W    = 9
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [15:0]       DATA,
    input  logic              WREN,
    output logic [15:0]       Q,
    input  logic              PAL_WREN,
    input  logic [BPP-1:0]    PAL_IDX,
    input  logic [15:0]       PAL_DATA,
    output logic              H_SYNC,
    output logic              V_SYNC,
    output logic [4:0]        V_R,
    output logic [5:0]        V_G,
    output logic [4:0]        V_B,
    output logic              V_BLANK,
    output logic              FRAME_START
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SW + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SW + V_BP;
    localparam int CPW      = 16 / BPP;
    localparam int COLS     = H_ACTIVE >> CELL_LOG2;
    localparam int ROWS     = V_ACTIVE >> CELL_LOG2;
    localparam int WPR      = COLS / CPW;
    localparam int WORDS    = WPR * ROWS;
    localparam int NPAL     = 1 << BPP;
    localparam int HW       = $clog2(H_TOTAL);
    localparam int VW       = $clog2(V_TOTAL);
    localparam int DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int FW       = (CPW > 1) ? $clog2(CPW) : 1;
    localparam int MAW      = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam logic SYNC_ON = 1'(SYNC_POL);

    logic [DW-1:0]  div_q, div_d;
    logic           pe;
    logic [HW-1:0]  hcnt_q, hcnt_d;
    logic [VW-1:0]  vcnt_q, vcnt_d;

    logic [31:0]    h32, v32, x_cell, y_cell, addr32;
    logic           act0, vact0, hs0, vs0, first0;
    logic [FW-1:0]  field0;
    logic [MAW-1:0] rd_addr;

    logic [15:0]    ram_rd_q;
    logic [FW-1:0]  field_q;
    logic           act1_q, vact1_q, hs1_q, vs1_q, first1_q;

    logic [15:0]    rgb_q;
    logic           hs2_q, vs2_q, vblank_q, fs_q;
    logic [BPP-1:0] pix_idx;

    logic [15:0]    tile_mem [WORDS];
    logic [15:0]    pal_q [NPAL];
    logic [15:0]    q_q;
    logic           addr_ok;
    logic [MAW-1:0] cpu_idx;

    always_comb begin
        pe     = (32'(div_q) == CLK_DIV - 1);
        div_d  = pe ? '0 : div_q + 1'b1;
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        h32    = 32'(hcnt_q);
        v32    = 32'(vcnt_q);
        if (pe) begin
            if (h32 == H_TOTAL - 1) begin
                hcnt_d = '0;
                vcnt_d = (v32 == V_TOTAL - 1) ? '0 : vcnt_q + 1'b1;
            end else begin
                hcnt_d = hcnt_q + 1'b1;
            end
        end

        act0   = (h32 < H_ACTIVE) && (v32 < V_ACTIVE);
        vact0  = (v32 < V_ACTIVE);
        hs0    = (h32 >= HS_START && h32 < HS_START + H_SW) ? SYNC_ON : ~SYNC_ON;
        vs0    = (v32 >= VS_START && v32 < VS_START + V_SW) ? SYNC_ON : ~SYNC_ON;
        first0 = (h32 == 0) && (v32 == 0);
        x_cell = h32 >> CELL_LOG2;
        y_cell = v32 >> CELL_LOG2;
        field0 = FW'(x_cell % CPW);
        addr32 = x_cell / CPW + y_cell * WPR;
        // Parked at word 0 in blanking so the read never leaves the array.
        rd_addr = act0 ? MAW'(addr32) : '0;

        // Leftmost cell lives in the most significant field of the word.
        pix_idx = BPP'(ram_rd_q >> (16 - BPP * (32'(field_q) + 1)));

        addr_ok = (32'(ADDR) < WORDS);
        cpu_idx = MAW'(ADDR);
    end

    always_ff @(posedge CLK) begin
        if (WREN && addr_ok) begin
            tile_mem[cpu_idx] <= DATA;
        end
        if (pe) begin
            ram_rd_q <= tile_mem[rd_addr];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            q_q <= '0;
        end else begin
            q_q <= addr_ok ? tile_mem[cpu_idx] : '0;
        end
    end

    for (genvar gi = 0; gi < NPAL; gi++) begin : g_pal
        localparam logic [15:0] PAL_RST = (gi == 0)        ? 16'hFFFF :
                                          (gi == NPAL - 1) ? 16'hF800 : 16'h001F;
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                pal_q[gi] <= PAL_RST;
            end else if (PAL_WREN && PAL_IDX == BPP'(gi)) begin
                pal_q[gi] <= PAL_DATA;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            div_q    <= '0;
            hcnt_q   <= '0;
            vcnt_q   <= '0;
            field_q  <= '0;
            act1_q   <= 1'b0;
            vact1_q  <= 1'b0;
            hs1_q    <= ~SYNC_ON;
            vs1_q    <= ~SYNC_ON;
            first1_q <= 1'b0;
            rgb_q    <= '0;
            hs2_q    <= ~SYNC_ON;
            vs2_q    <= ~SYNC_ON;
            vblank_q <= 1'b1;
            fs_q     <= 1'b0;
        end else begin
            div_q  <= div_d;
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
            // Single-CLK pulse, even when a pixel spans several CLKs.
            fs_q   <= pe && first1_q;
            if (pe) begin
                field_q  <= field0;
                act1_q   <= act0;
                vact1_q  <= vact0;
                hs1_q    <= hs0;
                vs1_q    <= vs0;
                first1_q <= first0;
                rgb_q    <= act1_q ? pal_q[pix_idx] : '0;
                hs2_q    <= hs1_q;
                vs2_q    <= vs1_q;
                vblank_q <= ~vact1_q;
            end
        end
    end

    assign Q           = q_q;
    assign H_SYNC      = hs2_q;
    assign V_SYNC      = vs2_q;
    assign V_R         = rgb_q[15:11];
    assign V_G         = rgb_q[10:5];
    assign V_B         = rgb_q[4:0];
    assign V_BLANK     = vblank_q;
    assign FRAME_START = fs_q;

endmodule

// File: tb/tb_gpu_tile_renderer.sv
// Randomized scoreboard bench for gpu_tile_renderer on a reduced screen geometry;
// a pixel-level reference model predicts Q and the video outputs every CLK.
module tb_gpu_tile_renderer;

    localparam int HA = 64, HFP = 4, HSW = 8, HBP = 4;
    localparam int VA = 32, VFP = 2, VSW = 2, VBP = 2;
    localparam int CLK_DIV = 2, CL = 3, BPP = 4, SP = 0, ADDR_W = 4;
    localparam int HT = HA + HFP + HSW + HBP;
    localparam int VT = VA + VFP + VSW + VBP;
    localparam int CPW = 16 / BPP;
    localparam int WPR = (HA >> CL) / CPW;
    localparam int WORDS = WPR * (VA >> CL);
    localparam int NPAL = 1 << BPP;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [ADDR_W-1:0] addr = '0;
    logic [15:0]       data = '0;
    logic              wren = 1'b0;
    logic [15:0]       q;
    logic              pal_wren = 1'b0;
    logic [BPP-1:0]    pal_idx = '0;
    logic [15:0]       pal_data = '0;
    logic              hs, vs, vblank, fstart;
    logic [4:0]        vr, vb_o;
    logic [5:0]        vg;

    gpu_tile_renderer #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SW(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SW(VSW), .V_BP(VBP),
        .CLK_DIV(CLK_DIV), .CELL_LOG2(CL), .BPP(BPP), .SYNC_POL(SP), .ADDR_W(ADDR_W)
    ) dut (
        .CLK(clk), .RST(rst), .ADDR(addr), .DATA(data), .WREN(wren), .Q(q),
        .PAL_WREN(pal_wren), .PAL_IDX(pal_idx), .PAL_DATA(pal_data),
        .H_SYNC(hs), .V_SYNC(vs), .V_R(vr), .V_G(vg), .V_B(vb_o),
        .V_BLANK(vblank), .FRAME_START(fstart)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] rgb;
        logic        hs, vs, vb, fs;
    } vid_t;

    typedef struct {
        bit act, vact, hon, von, first;
        int idx;
    } pix_t;

    vid_t        vid_exp[$];
    logic [15:0] q_exp[$];
    pix_t        pend[$];
    logic [15:0] mem_m [WORDS];
    logic [15:0] pal_m [NPAL];
    vid_t        out_m;
    int          pix, clk_cnt;
    int          tests = 0, fails = 0;
    bit          mon_en = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s: got %h, expected %h at t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic logic lvl(input bit on);
        return on ? 1'(SP) : ~1'(SP);
    endfunction

    task automatic check_reset_outputs(input string name);
        check(name, {32'd0, {vr, vg, vb_o}, q, hs, vs, vblank, fstart},
              {32'd0, 16'h0000, 16'h0000, lvl(0), lvl(0), 1'b1, 1'b0});
    endtask

    // RAM survives reset; everything else returns to power-on state.
    task automatic model_reset();
        pix_t blank;
        blank = '{act: 0, vact: 0, hon: 0, von: 0, first: 0, idx: 0};
        pend.delete();
        pend.push_back(blank);
        out_m = '{rgb: 16'h0, hs: lvl(0), vs: lvl(0), vb: 1'b1, fs: 1'b0};
        pix = 0;
        clk_cnt = 0;
        for (int i = 0; i < NPAL; i++)
            pal_m[i] = (i == 0) ? 16'hFFFF : (i == NPAL - 1) ? 16'hF800 : 16'h001F;
    endtask

    // Called at a negedge: drive inputs for the next posedge and predict its effect.
    task automatic step(input int cyc);
        bit   pe_n, act;
        int   h, v, waddr, a, k, word;
        pix_t r, nr;
        pe_n  = (clk_cnt % CLK_DIV) == CLK_DIV - 1;
        h     = pix % HT;
        v     = (pix / HT) % VT;
        act   = (h < HA) && (v < VA);
        waddr = (h >> CL) / CPW + (v >> CL) * WPR;

        wren     = ($urandom_range(0, 7) == 0);
        addr     = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
        if (pe_n && act && $urandom_range(0, 3) == 0) begin
            wren = 1'b1;
            addr = ADDR_W'(waddr);
        end
        data     = 16'($urandom);
        pal_wren = ($urandom_range(0, 39) == 0);
        pal_idx  = BPP'($urandom_range(0, NPAL - 1));
        pal_data = 16'($urandom);
        if (cyc == 3001) begin
            pal_wren = 1'b1;
            pal_idx  = BPP'(4'hA);
            pal_data = 16'h07E0;
        end

        a = int'(addr);
        q_exp.push_back(a < WORDS ? mem_m[a] : 16'h0000);

        if (pe_n) begin
            r = pend.pop_front();
            out_m.rgb = r.act ? pal_m[r.idx] : 16'h0000;
            out_m.hs  = lvl(r.hon);
            out_m.vs  = lvl(r.von);
            out_m.vb  = !r.vact;
            out_m.fs  = r.first;
            word      = act ? int'(mem_m[waddr]) : 0;
            k         = (h >> CL) % CPW;
            nr.act    = act;
            nr.vact   = (v < VA);
            nr.hon    = (h >= HA + HFP) && (h < HA + HFP + HSW);
            nr.von    = (v >= VA + VFP) && (v < VA + VFP + VSW);
            nr.first  = (h == 0) && (v == 0);
            nr.idx    = (word >> (16 - BPP * (k + 1))) & (NPAL - 1);
            pend.push_back(nr);
            pix++;
        end else begin
            out_m.fs = 1'b0;
        end
        vid_exp.push_back(out_m);

        if (wren && a < WORDS) mem_m[a] = data;
        if (pal_wren) pal_m[int'(pal_idx)] = pal_data;
        clk_cnt++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            step(i);
            @(negedge clk);
        end
    endtask

    initial begin : monitor
        vid_t        e;
        logic [15:0] eq;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (q_exp.size() > 0) begin
                    eq = q_exp.pop_front();
                    check("cpu_q", {48'd0, q}, {48'd0, eq});
                end
                if (vid_exp.size() > 0) begin
                    e = vid_exp.pop_front();
                    check("video{rgb,hs,vs,vblank,fs}",
                          {44'd0, vr, vg, vb_o, hs, vs, vblank, fstart},
                          {44'd0, e.rgb, e.hs, e.vs, e.vb, e.fs});
                end
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("reset_state");

        // Load every tile word, then reset again: RAM must keep its contents.
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < WORDS; i++) begin
            wren = 1'b1;
            addr = ADDR_W'(i);
            data = (i == 0) ? 16'h0AF0 : 16'($urandom);
            mem_m[i] = data;
            @(negedge clk);
        end
        wren = 1'b0;
        rst  = 1'b1;
        #1 check_reset_outputs("reset_after_load");
        model_reset();
        @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;
        run(8021);

        // Asynchronous reset in the middle of an active line.
        #2;
        mon_en   = 1'b0;
        rst      = 1'b1;
        wren     = 1'b0;
        pal_wren = 1'b0;
        #1 check_reset_outputs("async_reset_midline");
        q_exp.delete();
        vid_exp.delete();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;
        run(7000);

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
